// File: rtl/pm_loader.sv
// pm_loader: byte-stream writer for the 256x8 program memory.
// Accepts a framed image (START_BYTE, length, data..., checksum) over a valid/ready byte
// interface, writes each data byte to consecutive addresses from 0x00, and holds the CPU
// in reset while a frame is in progress or after a failed load.
// Latency: a data byte accepted at edge k appears as a write strobe in the cycle after edge k.
// Backpressure: i_in_valid/o_in_ready; o_in_ready is low only during the one-cycle RESULT state.
// Ports:
//   i_clk, i_reset        clock (rising edge), asynchronous active-high reset
//   i_in_data/i_in_valid  incoming stream byte and its valid
//   o_in_ready            loader can take a byte this cycle
//   o_pm_wr_addr/_data    program-memory write address/data, valid with o_pm_wren
//   o_pm_wren             one-cycle write strobe
//   o_cpu_hold            hold processor in reset
//   o_load_done           one-cycle pulse: frame received with good checksum
//   o_load_error          sticky bad-checksum/timeout flag, cleared on next START_BYTE
//   o_bytes_loaded        data bytes written in the current/last frame (0..256)
module pm_loader #(
  parameter logic [7:0] START_BYTE     = 8'hA5,
  parameter int         TIMEOUT_CYCLES = 1024,
  parameter int         TO_W           = 11
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [7:0] i_in_data,
  input  logic       i_in_valid,
  output logic       o_in_ready,
  output logic [7:0] o_pm_wr_addr,
  output logic [7:0] o_pm_wr_data,
  output logic       o_pm_wren,
  output logic       o_cpu_hold,
  output logic       o_load_done,
  output logic       o_load_error,
  output logic [8:0] o_bytes_loaded
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LEN    = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_CSUM   = 3'd3;
  localparam logic [2:0] S_RESULT = 3'd4;

  // Counter value at which the next idle cycle is the TIMEOUT_CYCLES-th one.
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  logic [2:0]      r_state;
  logic [8:0]      r_remaining;
  logic [7:0]      r_index;
  logic [7:0]      r_sum;
  logic [TO_W-1:0] r_to_cnt;
  logic [7:0]      r_wr_addr;
  logic [7:0]      r_wr_data;
  logic            r_wren;
  logic            r_hold;
  logic            r_done;
  logic            r_error;
  logic [8:0]      r_bytes;

  logic w_ready;
  logic w_accept;
  logic w_in_frame;
  logic w_expire;

  assign w_ready    = (r_state != S_RESULT);
  assign w_accept   = i_in_valid && w_ready;
  assign w_in_frame = (r_state == S_LEN) || (r_state == S_DATA) || (r_state == S_CSUM);
  // An accept in the expiry cycle takes priority over the timeout.
  assign w_expire   = w_in_frame && !w_accept && (r_to_cnt == TO_LAST);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state     <= S_IDLE;
      r_remaining <= 9'd0;
      r_index     <= 8'd0;
      r_sum       <= 8'd0;
      r_to_cnt    <= '0;
      r_wr_addr   <= 8'd0;
      r_wr_data   <= 8'd0;
      r_wren      <= 1'b0;
      r_hold      <= 1'b0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
      r_bytes     <= 9'd0;
    end else begin
      r_wren <= 1'b0;
      r_done <= 1'b0;

      // Idle-cycle counter only runs inside a frame; any accept reloads it.
      if (!w_in_frame || w_accept || w_expire) begin
        r_to_cnt <= '0;
      end else begin
        r_to_cnt <= r_to_cnt + 1'b1;
      end

      case (r_state)
        S_IDLE: begin
          if (w_accept && (i_in_data == START_BYTE)) begin
            r_state <= S_LEN;
            r_hold  <= 1'b1;
            r_error <= 1'b0;
            r_bytes <= 9'd0;
            r_sum   <= 8'd0;
          end
        end

        S_LEN: begin
          if (w_accept) begin
            // Length 0 encodes a full 256-byte image.
            r_remaining <= (i_in_data == 8'h00) ? 9'd256 : {1'b0, i_in_data};
            r_sum       <= i_in_data;
            r_index     <= 8'd0;
            r_state     <= S_DATA;
          end else if (w_expire) begin
            r_error <= 1'b1;
            r_state <= S_IDLE;
          end
        end

        S_DATA: begin
          if (w_accept) begin
            r_wren      <= 1'b1;
            r_wr_addr   <= r_index;
            r_wr_data   <= i_in_data;
            r_index     <= r_index + 8'd1;
            r_sum       <= r_sum + i_in_data;
            r_bytes     <= r_bytes + 9'd1;
            r_remaining <= r_remaining - 9'd1;
            if (r_remaining == 9'd1) begin
              r_state <= S_CSUM;
            end
          end else if (w_expire) begin
            r_error <= 1'b1;
            r_state <= S_IDLE;
          end
        end

        S_CSUM: begin
          if (w_accept) begin
            r_sum   <= r_sum + i_in_data;
            r_state <= S_RESULT;
          end else if (w_expire) begin
            r_error <= 1'b1;
            r_state <= S_IDLE;
          end
        end

        S_RESULT: begin
          // Length + data + checksum must sum to zero mod 256.
          if (r_sum == 8'h00) begin
            r_done <= 1'b1;
            r_hold <= 1'b0;
          end else begin
            r_error <= 1'b1;
          end
          r_state <= S_IDLE;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_in_ready     = w_ready;
  assign o_pm_wr_addr   = r_wr_addr;
  assign o_pm_wr_data   = r_wr_data;
  assign o_pm_wren      = r_wren;
  assign o_cpu_hold     = r_hold;
  assign o_load_done    = r_done;
  assign o_load_error   = r_error;
  assign o_bytes_loaded = r_bytes;

endmodule

// File: tb/tb_pm_loader.sv
// tb_pm_loader: self-checking bench for pm_loader.
// Table of per-cycle stimulus/expected outputs for the basic frame flows, then hand-written
// sequences for timeout, expiry-cycle accept, 256-byte image and reset mid-frame.
module tb_pm_loader;

  logic       clk;
  logic       rst;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic       wren;
  logic       hold;
  logic       done;
  logic       err;
  logic [8:0] bl;

  int checks;
  int failures;

  pm_loader dut (
    .i_clk          (clk),
    .i_reset        (rst),
    .i_in_data      (in_data),
    .i_in_valid     (in_valid),
    .o_in_ready     (in_ready),
    .o_pm_wr_addr   (wr_addr),
    .o_pm_wr_data   (wr_data),
    .o_pm_wren      (wren),
    .o_cpu_hold     (hold),
    .o_load_done    (done),
    .o_load_error   (err),
    .o_bytes_loaded (bl)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       vld;
    logic [7:0] dat;
    logic       rdy;
    logic       wren;
    logic [7:0] addr;
    logic [7:0] data;
    logic       done;
    logic       err;
    logic       hold;
    logic [8:0] bl;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic v, input logic [7:0] d, input logic r,
                              input logic w, input logic [7:0] a, input logic [7:0] wd,
                              input logic dn, input logic e, input logic h, input logic [8:0] b);
    vec_t x;
    x.vld = v; x.dat = d; x.rdy = r; x.wren = w; x.addr = a; x.data = wd;
    x.done = dn; x.err = e; x.hold = h; x.bl = b;
    tbl.push_back(x);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Drive one byte (or idle) for one clock edge, then sample 1ns after the edge.
  task automatic step(input logic v, input logic [7:0] d);
    @(negedge clk);
    in_valid = v;
    in_data  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_write(input string nm, input logic [7:0] a, input logic [7:0] d);
    chk({nm, "_wren"}, {31'd0, wren}, 32'd1);
    chk({nm, "_addr"}, {24'd0, wr_addr}, {24'd0, a});
    chk({nm, "_data"}, {24'd0, wr_data}, {24'd0, d});
  endtask

  initial begin
    int wcnt;
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;

    // ---------------- reset state ----------------
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_wren",  {31'd0, wren}, 32'd0);
    chk("rst_hold",  {31'd0, hold}, 32'd0);
    chk("rst_done",  {31'd0, done}, 32'd0);
    chk("rst_err",   {31'd0, err}, 32'd0);
    chk("rst_addr",  {24'd0, wr_addr}, 32'd0);
    chk("rst_data",  {24'd0, wr_data}, 32'd0);
    chk("rst_bl",    {23'd0, bl}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // ---------------- table-driven frames ----------------
    // v  dat    rdy wr addr   data   dn er hd bl
    // junk before START is dropped
    add(1, 8'h00, 1, 0, 8'h00, 8'h00, 0, 0, 0, 0);
    add(1, 8'hFF, 1, 0, 8'h00, 8'h00, 0, 0, 0, 0);
    add(1, 8'h5A, 1, 0, 8'h00, 8'h00, 0, 0, 0, 0);
    // good frame A5,03,C8,01,(stall),12,22
    add(1, 8'hA5, 1, 0, 8'h00, 8'h00, 0, 0, 1, 0);
    add(1, 8'h03, 1, 0, 8'h00, 8'h00, 0, 0, 1, 0);
    add(1, 8'hC8, 1, 1, 8'h00, 8'hC8, 0, 0, 1, 1);
    add(1, 8'h01, 1, 1, 8'h01, 8'h01, 0, 0, 1, 2);
    add(0, 8'h00, 1, 0, 8'h00, 8'h00, 0, 0, 1, 2);
    add(1, 8'h12, 1, 1, 8'h02, 8'h12, 0, 0, 1, 3);
    add(1, 8'h22, 0, 0, 8'h00, 8'h00, 0, 0, 1, 3);
    add(1, 8'h5A, 1, 0, 8'h00, 8'h00, 1, 0, 0, 3);  // not taken in RESULT
    add(1, 8'h5A, 1, 0, 8'h00, 8'h00, 0, 0, 0, 3);  // dropped in IDLE
    // bad checksum frame
    add(1, 8'hA5, 1, 0, 8'h00, 8'h00, 0, 0, 1, 0);
    add(1, 8'h03, 1, 0, 8'h00, 8'h00, 0, 0, 1, 0);
    add(1, 8'hC8, 1, 1, 8'h00, 8'hC8, 0, 0, 1, 1);
    add(1, 8'h01, 1, 1, 8'h01, 8'h01, 0, 0, 1, 2);
    add(1, 8'h12, 1, 1, 8'h02, 8'h12, 0, 0, 1, 3);
    add(1, 8'h23, 0, 0, 8'h00, 8'h00, 0, 0, 1, 3);
    add(0, 8'h00, 1, 0, 8'h00, 8'h00, 0, 1, 1, 3);
    add(0, 8'h00, 1, 0, 8'h00, 8'h00, 0, 1, 1, 3);
    // next START clears the error, good 1-byte frame releases hold
    add(1, 8'hA5, 1, 0, 8'h00, 8'h00, 0, 0, 1, 0);
    add(1, 8'h01, 1, 0, 8'h00, 8'h00, 0, 0, 1, 0);
    add(1, 8'hC8, 1, 1, 8'h00, 8'hC8, 0, 0, 1, 1);
    add(1, 8'h37, 0, 0, 8'h00, 8'h00, 0, 0, 1, 1);
    add(0, 8'h00, 1, 0, 8'h00, 8'h00, 1, 0, 0, 1);
    add(0, 8'h00, 1, 0, 8'h00, 8'h00, 0, 0, 0, 1);

    foreach (tbl[i]) begin
      step(tbl[i].vld, tbl[i].dat);
      chk($sformatf("v%0d_rdy", i),  {31'd0, in_ready}, {31'd0, tbl[i].rdy});
      chk($sformatf("v%0d_wren", i), {31'd0, wren},     {31'd0, tbl[i].wren});
      chk($sformatf("v%0d_done", i), {31'd0, done},     {31'd0, tbl[i].done});
      chk($sformatf("v%0d_err", i),  {31'd0, err},      {31'd0, tbl[i].err});
      chk($sformatf("v%0d_hold", i), {31'd0, hold},     {31'd0, tbl[i].hold});
      chk($sformatf("v%0d_bl", i),   {23'd0, bl},       {23'd0, tbl[i].bl});
      if (tbl[i].wren) begin
        chk($sformatf("v%0d_addr", i), {24'd0, wr_addr}, {24'd0, tbl[i].addr});
        chk($sformatf("v%0d_data", i), {24'd0, wr_data}, {24'd0, tbl[i].data});
      end
    end

    // ---------------- timeout: A5,02,7E then silence ----------------
    step(1, 8'hA5);
    step(1, 8'h02);
    step(1, 8'h7E);
    chk_write("to_w0", 8'h00, 8'h7E);
    wcnt = 0;
    for (int k = 0; k < 1023; k++) begin
      step(0, 8'h00);
      if (wren) wcnt++;
    end
    chk("to_early_err", {31'd0, err}, 32'd0);
    step(0, 8'h00);
    chk("to_err",    {31'd0, err}, 32'd1);
    chk("to_hold",   {31'd0, hold}, 32'd1);
    chk("to_ready",  {31'd0, in_ready}, 32'd1);
    chk("to_nowr",   wcnt, 32'd0);
    chk("to_bl",     {23'd0, bl}, 32'd1);
    step(0, 8'h00);
    chk("to_sticky", {31'd0, err}, 32'd1);

    // ---------------- accept in the expiry cycle wins ----------------
    step(1, 8'hA5);
    chk("ex_errclr", {31'd0, err}, 32'd0);
    step(1, 8'h02);
    step(1, 8'h7E);
    for (int k = 0; k < 1023; k++) step(0, 8'h00);
    step(1, 8'h01);
    chk_write("ex_w1", 8'h01, 8'h01);
    chk("ex_err", {31'd0, err}, 32'd0);
    step(1, 8'h7F);
    step(0, 8'h00);
    chk("ex_done", {31'd0, done}, 32'd1);
    chk("ex_hold", {31'd0, hold}, 32'd0);

    // ---------------- full 256-byte image ----------------
    step(1, 8'hA5);
    step(1, 8'h00);
    for (int k = 0; k < 256; k++) begin
      step(1, 8'(k));
      chk_write($sformatf("full_%0d", k), 8'(k), 8'(k));
    end
    chk("full_bl", {23'd0, bl}, 32'd256);
    step(1, 8'h80);
    chk("full_rdy", {31'd0, in_ready}, 32'd0);
    step(0, 8'h00);
    chk("full_done", {31'd0, done}, 32'd1);
    chk("full_hold", {31'd0, hold}, 32'd0);
    chk("full_last", {24'd0, wr_addr}, 32'hFF);

    // ---------------- reset mid-frame ----------------
    step(1, 8'hA5);
    step(1, 8'h04);
    step(1, 8'h11);
    step(1, 8'h22);
    chk_write("mr_w1", 8'h01, 8'h22);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 8'h33;
    rst      = 1'b1;
    #1;
    chk("mr_wren", {31'd0, wren}, 32'd0);
    chk("mr_hold", {31'd0, hold}, 32'd0);
    chk("mr_bl",   {23'd0, bl}, 32'd0);
    chk("mr_addr", {24'd0, wr_addr}, 32'd0);
    chk("mr_data", {24'd0, wr_data}, 32'd0);
    chk("mr_rdy",  {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    chk("mr_held_wren", {31'd0, wren}, 32'd0);
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;
    step(1, 8'hA5);
    step(1, 8'h01);
    step(1, 8'hC8);
    chk_write("mr_new", 8'h00, 8'hC8);
    step(1, 8'h37);
    step(0, 8'h00);
    chk("mr_done", {31'd0, done}, 32'd1);
    chk("mr_err",  {31'd0, err}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
